// File: rtl/rotation_shift_arbiter.sv
// Two-requester round-robin arbiter feeding one shared rotate-right unit and a one-entry result register.
// Latency: an operand accepted in cycle t appears on o_res_data/o_res_id with o_res_valid=1 in cycle t+1.
// Backpressure: readies drop while the result is held and undrained; a drain and a new accept can share a cycle.
module rotation_shift_arbiter #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_req0_valid,
    input  logic [N-1:0] i_req0_num,
    input  logic [2:0]   i_req0_amt,
    input  logic         i_req1_valid,
    input  logic [N-1:0] i_req1_num,
    input  logic [2:0]   i_req1_amt,
    output logic         o_req0_ready,
    output logic         o_req1_ready,
    output logic         o_res_valid,
    output logic [N-1:0] o_res_data,
    output logic         o_res_id,
    input  logic         i_res_ready,
    output logic [7:0]   o_cnt0,
    output logic [7:0]   o_cnt1,
    output logic         o_busy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         state;
    logic           last_grant;
    logic           slot_free;
    logic           pick0;
    logic           pick1;
    logic           accept;
    logic [N-1:0]   sel_num;
    logic [2:0]     sel_amt;
    logic [2*N-1:0] rot_dbl;
    logic [N-1:0]   rot_res;

    assign o_res_valid = (state == FULL);
    assign o_busy      = o_res_valid;
    assign slot_free   = (state == EMPTY) | (o_res_valid & i_res_ready);

    // On a tie the requester that was not granted last wins.
    assign pick0 = i_req0_valid & (~i_req1_valid | last_grant);
    assign pick1 = i_req1_valid & (~i_req0_valid | ~last_grant);

    assign o_req0_ready = ~i_reset & slot_free & pick0;
    assign o_req1_ready = ~i_reset & slot_free & pick1;
    assign accept       = o_req0_ready | o_req1_ready;

    assign sel_num = o_req1_ready ? i_req1_num : i_req0_num;
    assign sel_amt = o_req1_ready ? i_req1_amt : i_req0_amt;

    // Shifting the doubled word right leaves the rotated word in the low half.
    assign rot_dbl = {sel_num, sel_num} >> sel_amt;
    assign rot_res = rot_dbl[N-1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            o_res_data <= '0;
            o_res_id   <= 1'b0;
            o_cnt0     <= 8'd0;
            o_cnt1     <= 8'd0;
        end else begin
            if (accept) begin
                state      <= FULL;
                o_res_data <= rot_res;
                o_res_id   <= o_req1_ready;
                last_grant <= o_req1_ready;
                if (o_req0_ready && o_cnt0 != 8'hFF) begin
                    o_cnt0 <= o_cnt0 + 8'd1;
                end
                if (o_req1_ready && o_cnt1 != 8'hFF) begin
                    o_cnt1 <= o_cnt1 + 8'd1;
                end
            end else if (o_res_valid && i_res_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: doc/rotation_shift_arbiter.md
ROTATION_SHIFT_ARBITER -- requirements
Module: rotation_shift_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, data width; only N=8 is supported because the rotation amount is fixed at 3 bits.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports i_req0_valid / i_req1_valid  input  1  requester k presents an operand.
REQ-005 SHALL have ports i_req0_num / i_req1_num  input  N  word to rotate for requester k.
REQ-006 SHALL have ports i_req0_amt / i_req1_amt  input  3  right-rotation amount, 0..7.
REQ-007 SHALL have ports o_req0_ready / o_req1_ready  output  1  operand of requester k is accepted this cycle.
REQ-008 SHALL have port o_res_valid  output  1  result register holds a valid result.
REQ-009 SHALL have port o_res_data  output  N  rotated word.
REQ-010 SHALL have port o_res_id  output  1  requester index (0/1) that owns o_res_data.
REQ-011 SHALL have port i_res_ready  input  1  consumer accepts the result.
REQ-012 SHALL have ports o_cnt0 / o_cnt1  output  8  accepted-transaction counters per requester.
REQ-013 SHALL have port o_busy  output  1  result register full (equals o_res_valid).

Function
REQ-014 SHALL instantiate one shared combinational rotate-right datapath: result = {num[amt-1:0], num[N-1:amt]}, with amt=0 giving num unchanged.
REQ-015 SHALL keep a 2-state FSM: EMPTY (no result held) and FULL (result held).
REQ-016 SHALL define slot_free = (state==EMPTY) | (o_res_valid & i_res_ready).
REQ-017 SHALL assert at most one of o_req0_ready / o_req1_ready per cycle, and only when slot_free=1 and the corresponding valid is 1.
REQ-018 SHALL arbitrate round-robin: if one requester is valid it wins; if both are valid, the requester not granted last wins.
REQ-019 SHALL update the last-granted pointer only on an accept (valid & ready).
REQ-020 SHALL, on accept, register the rotated word and requester index so they appear on o_res_data / o_res_id with o_res_valid=1 in the next cycle (latency 1).
REQ-021 SHALL hold o_res_data, o_res_id and o_res_valid stable while o_res_valid=1 and i_res_ready=0.
REQ-022 SHALL follow these FSM transitions:
- EMPTY + accept -> FULL.
- EMPTY + no accept -> EMPTY.
- FULL + drain + accept -> FULL, loaded with new data (back-to-back, no bubble).
- FULL + drain + no accept -> EMPTY, o_res_valid=0.
- FULL + no drain -> FULL, both readies 0.
REQ-023 SHALL compute ready combinationally from the valids and state; requesters SHALL NOT make valid depend on ready.
REQ-024 SHALL increment o_cntk by 1 per accept of requester k, saturating at 255 (no wrap).
REQ-025 SHALL have o_res_data / o_res_id values that are don't-care while o_res_valid=0, but they SHALL retain the last loaded value.

Reset
REQ-026 SHALL, in a cycle with i_reset=1, force on the next edge: state EMPTY, o_res_valid=0, o_res_data=0, o_res_id=0, o_cnt0=o_cnt1=0, last-granted pointer=1 (so req0 wins the first tie).
REQ-027 SHALL hold both readies at 0 while i_reset=1, and discard any held result on a reset in FULL.

Verification
REQ-028 SHALL cover single request: req0 num=0xB1 amt=1, i_res_ready=1 -> ready0 same cycle; next cycle o_res_valid=1, data=0xD8, id=0.
REQ-029 SHALL cover rotation boundaries: amt=0 on 0x5A -> 0x5A; 0x01 amt=4 -> 0x10; 0x81 amt=7 -> 0x03.
REQ-030 SHALL cover a tie after reset: req0 0xB1/1 and req1 0x01/4 valid together, consumer always ready -> results 0xD8 id0, then 0x10 id1 on consecutive cycles; with both held valid, grants alternate 0,1,0,1.
REQ-031 SHALL cover backpressure: result FULL, i_res_ready=0 for 3 cycles with both valids high -> readies 0, outputs unchanged; the cycle i_res_ready=1 -> drain plus new accept, no bubble.
REQ-032 SHALL cover counter saturation: 260 accepts on req0 -> o_cnt0=255, o_cnt1=0.
REQ-033 SHALL cover reset mid-operation: i_reset=1 while FULL and i_res_ready=0 -> o_res_valid=0, counters 0 after the edge; first post-reset tie is granted to req0.
